// File: rtl/data_mem_stage.sv
// MEM-stage data memory: multi-cycle word load/store with pipeline stall and done pulse.
// Optional per-byte store lanes are enabled by defining DMEM_BYTE_EN.
module data_mem_stage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [3:0]    lane_en_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic req;
  logic aligned;
  logic commit;
  logic unused_addr;

  assign req     = mem_read | mem_write;
  assign aligned = (addr[1:0] == 2'b00);
  assign stall   = (state_q == StIdle && req && aligned) || (state_q == StAccess);
  assign commit  = (state_q == StAccess) && (cnt_q == CW'(1));

  // Upper address bits are dropped on purpose so out-of-range addresses wrap.
  assign unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      read_data      <= '0;
      done           <= 1'b0;
      misaligned_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (aligned) begin
              idx_q   <= addr[AW+1:2];
              wdata_q <= write_data;
              wr_q    <= mem_write;  // read+write together is a store
`ifdef DMEM_BYTE_EN
              lane_en_q <= byte_en;
`else
              lane_en_q <= 4'hF;
`endif
              cnt_q   <= CW'(WAIT_CYCLES);
              state_q <= StAccess;
            end else begin
              misaligned_err <= 1'b1;
            end
          end
        end
        StAccess: begin
          cnt_q <= cnt_q - CW'(1);
          if (commit) begin
            if (!wr_q) read_data <= mem[idx_q];
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        // The still-present request is not restarted from here.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array has no reset; a reset during ACCESS suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_q) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en_q[l]) mem[idx_q][8*l +: 8] <= wdata_q[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: cycle-timeline model checked every cycle plus literal expectations.
module tb_data_mem_stage;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
`ifdef DMEM_BYTE_EN
  logic [3:0]  byte_en = 4'hF;
`endif
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        misaligned_err;

  int total = 0;
  int bad   = 0;

  data_mem_stage #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .addr          (addr),
    .write_data    (write_data),
`ifdef DMEM_BYTE_EN
    .byte_en       (byte_en),
`endif
    .read_data     (read_data),
    .stall         (stall),
    .done          (done),
    .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endfunction

  // Model: an accepted op at cycle S stalls cycles S..S+W, completes at edge ending S+W,
  // and shows done in cycle S+W+1.
  bit          checking = 1'b0;
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_be = 4'hF;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;
  bit          m_mis_pend = 1'b0;
  logic [31:0] m_mem [DEPTH];

  always @(negedge clk) begin
    if (checking) begin
      int   age;
      logic exp_stall;
      logic exp_done;
      if (!m_active && (mem_read || mem_write)) begin
        if (addr[1:0] == 2'b00) begin
          m_active = 1'b1;
          m_start  = cyc;
          m_wr     = mem_write;
          m_addr   = addr;
          m_data   = write_data;
`ifdef DMEM_BYTE_EN
          m_be     = byte_en;
`endif
        end else begin
          m_mis_pend = 1'b1;
        end
      end
      age       = cyc - m_start;
      exp_stall = m_active && (age <= W);
      exp_done  = m_active && (age == W + 1);
      check("cyc_stall", 32'(stall), 32'(exp_stall));
      check("cyc_done", 32'(done), 32'(exp_done));
      check("cyc_read_data", read_data, m_rdata);
      check("cyc_misaligned_err", 32'(misaligned_err), 32'(m_err));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_rdata  = '0;
      m_err    = 1'b0;
    end else begin
      if (m_mis_pend) m_err = 1'b1;
      if (m_active && (cyc - m_start == W)) begin
        if (m_wr) begin
          for (int l = 0; l < 4; l++)
            if (m_be[l]) m_mem[m_addr[9:2]][8*l +: 8] = m_data[8*l +: 8];
        end else begin
          m_rdata = m_mem[m_addr[9:2]];
        end
      end else if (m_active && (cyc - m_start == W + 1)) begin
        m_active = 1'b0;
      end
    end
    m_mis_pend = 1'b0;
    cyc++;
  end

  task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, output logic [31:0] rv);
    int stalls;
    bit seen;
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = d;
    stalls = 0;
    seen   = 1'b0;
    rv     = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        seen = 1'b1;
        rv   = read_data;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL op_timeout: got no done want done within 20 cycles");
    end
    check("stall_cycles", 32'(stalls), 32'(W + 1));
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  logic [31:0] rv;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(misaligned_err), 32'h0);

    op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rv);
    idle(1);
    op(1'b1, 1'b0, 32'h10, 32'h0, rv);
    check("load_0x10", rv, 32'hDEADBEEF);
    idle(1);
    op(1'b0, 1'b1, 32'h14, 32'h12345678, rv);
    check("store_keeps_read_data", read_data, 32'hDEADBEEF);
    idle(1);

    // Back-to-back loads: second request appears right after the DONE cycle.
    op(1'b1, 1'b0, 32'h10, 32'h0, rv);
    check("b2b_load_0x10", rv, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'h14, 32'h0, rv);
    check("b2b_load_0x14", rv, 32'h12345678);
    idle(1);

    op(1'b1, 1'b1, 32'h30, 32'h0BADF00D, rv);
    idle(1);
    op(1'b1, 1'b0, 32'h30, 32'h0, rv);
    check("rw_is_store", rv, 32'h0BADF00D);
    idle(1);

    op(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, rv);
    idle(1);
    op(1'b1, 1'b0, 32'h0, 32'h0, rv);
    check("addr_wrap", rv, 32'hA5A5A5A5);
    idle(1);

    // Misaligned load
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    addr     = 32'h13;
    @(negedge clk);
    check("mis_no_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("mis_err_next", 32'(misaligned_err), 32'h1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mis_err_sticky", 32'(misaligned_err), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mis_err_cleared", 32'(misaligned_err), 32'h0);

    // Reset during the first ACCESS cycle of a store
    op(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, rv);
    idle(1);
    op(1'b1, 1'b0, 32'h20, 32'h0, rv);
    idle(1);
    @(posedge clk);
    #1;
    mem_write  = 1'b1;
    addr       = 32'h20;
    write_data = 32'h11111111;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("abort_read_data", read_data, 32'h0);
    check("abort_stall", 32'(stall), 32'h0);
    idle(1);
    op(1'b1, 1'b0, 32'h20, 32'h0, rv);
    check("abort_no_commit", rv, 32'hCAFEF00D);
    idle(1);

`ifdef DMEM_BYTE_EN
    byte_en = 4'hF;
    op(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, rv);
    idle(1);
    byte_en = 4'b0101;
    op(1'b0, 1'b1, 32'h20, 32'h00000000, rv);
    idle(1);
    byte_en = 4'b0000;
    op(1'b0, 1'b1, 32'h20, 32'h12121212, rv);
    idle(1);
    byte_en = 4'b0000;
    op(1'b1, 1'b0, 32'h20, 32'h0, rv);
    check("byte_en_lanes", rv, 32'hFF00FF00);
    idle(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
